// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares a single FIFO write port among N producers.
// An owner keeps the grant for at most BURST accepted words. The grant is then
// released through one IDLE cycle, and the search restarts after the last owner.
// Handshake: a requester's word is taken on the rising edge where
// ack[i]=1. ack[i] is high only when requester i owns the grant, req[i]=1
// and fifo_full=0. The requester keeps req[i] and its data stable until that
// edge. fifo_wr and ack[owner] are the same signal, so the FIFO write and the
// requester handshake always happen together.
module fifo_wr_arbiter #(
    parameter int B     = 8,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*B-1:0] data,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    input  logic           fifo_full,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_w_data,
    output logic           dbg_state
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_last_owner;
    logic [CW-1:0]   r_cnt;

    logic            w_found;
    logic [OW-1:0]   w_next_owner;
    logic [N-1:0]    w_next_grant;
    logic            w_owner_req;
    logic [B-1:0]    w_owner_data;
    logic            w_wr;
    logic            w_last_word;

    // Round-robin search that starts one past the last owner and wraps modulo N
    always_comb begin
        w_found      = 1'b0;
        w_next_owner = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(r_last_owner) + k) % N;
            if (!w_found && req[idx]) begin
                w_found      = 1'b1;
                w_next_owner = OW'(idx);
            end
        end
    end

    assign w_next_grant = {{(N-1){1'b0}}, 1'b1} << w_next_owner;

    // Select the current owner's request bit and data word
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == OW'(i)) begin
                w_owner_req  = req[i];
                w_owner_data = data[i*B +: B];
            end
        end
    end

    // A word is written only while granted, presented and the FIFO has room
    assign w_wr        = (r_state == S_GRANT) && w_owner_req && !fifo_full;
    assign w_last_word = (r_cnt == CW'(BURST - 1));

    // The owner's ack mirrors the write strobe; non-owner bits stay zero
    always_comb begin
        ack = '0;
        if (w_wr) begin
            ack = r_grant;
        end
    end

    assign fifo_wr     = w_wr;
    assign fifo_w_data = w_owner_data;
    assign grant       = r_grant;
    assign dbg_state   = r_state;

    // Arbitration FSM: IDLE picks an owner, GRANT streams until burst end or req drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_last_owner <= OW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_next_owner;
                        r_grant <= w_next_grant;
                        r_cnt   <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_wr) begin
                        if (w_last_word) begin
                            r_state      <= S_IDLE;
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (!w_owner_req) begin
                        // Owner went quiet: give the port back without writing
                        r_state      <= S_IDLE;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                    end
                    // Otherwise the FIFO is full: hold grant and count
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (B=8, N=4, BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_w_data;
    logic        dbg_state;

    fifo_wr_arbiter #(.B(8), .N(4), .BURST(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data(data),
        .ack(ack),
        .grant(grant),
        .fifo_full(fifo_full),
        .fifo_wr(fifo_wr),
        .fifo_w_data(fifo_w_data),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // requester word sources
    logic [7:0] words[4][8];
    int         head[4];
    int         len[4];

    // scoreboard
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] glog_q[$];
    logic [7:0] exp_g[$];
    logic [3:0] prev_grant;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic [3:0]  e_grant;
        logic [3:0]  e_ack;
        logic        e_wr;
        logic [7:0]  e_wdata;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        glog_q.delete();
        exp_g.delete();
        prev_grant = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = 4'b0000;
        data      = 32'h0;
        fifo_full = 1'b0;
        clear_sb();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load(input int r, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) words[r][k] = base + 8'(k);
        head[r] = 0;
        len[r]  = n;
    endtask

    // driver: each enabled requester with words left presents its head word
    task automatic drive(input logic [3:0] en, input logic full);
        for (int i = 0; i < 4; i++) begin
            if (en[i] && head[i] < len[i]) begin
                req[i]         = 1'b1;
                data[i*8 +: 8] = words[i][head[i]];
            end else begin
                req[i]         = 1'b0;
                data[i*8 +: 8] = 8'h00;
            end
        end
        fifo_full = full;
    endtask

    // monitor: record writes and new grants, pop acked words
    task automatic sample();
        check("no_wr_when_full", {31'b0, fifo_wr & fifo_full}, 32'd0);
        check("ack_onehot0", {31'b0, $onehot0(ack)}, 32'd1);
        check("ack_non_owner", {28'b0, ack & ~grant}, 32'd0);
        if (fifo_wr) got_q.push_back(fifo_w_data);
        if (grant != 4'b0000 && prev_grant == 4'b0000) glog_q.push_back({4'b0, grant});
        prev_grant = grant;
        for (int i = 0; i < 4; i++) if (ack[i]) head[i]++;
    endtask

    task automatic step(input logic [3:0] en, input logic full);
        @(negedge clk);
        drive(en, full);
        #2;
        sample();
    endtask

    task automatic cmp_fifo(input string name);
        check({name, "_fifo_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_fifo_word"}, {24'b0, got_q[i]}, {24'b0, exp_q[i]});
    endtask

    task automatic cmp_grants(input string name);
        check({name, "_grant_cnt"}, glog_q.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < glog_q.size(); i++)
            check({name, "_grant_seq"}, {24'b0, glog_q[i]}, {24'b0, exp_g[i]});
    endtask

    initial begin
        reset     = 1'b0;
        req       = 4'hF;
        data      = 32'h33221100;
        fifo_full = 1'b0;
        clear_sb();

        // reset holds everything off even with all requests active
        @(negedge clk);
        #2;
        check("rst_grant", {28'b0, grant}, 32'h0);
        check("rst_ack", {28'b0, ack}, 32'h0);
        check("rst_wr", {31'b0, fifo_wr}, 32'h0);
        check("rst_state", {31'b0, dbg_state}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("rst_first_grant", {28'b0, grant}, 32'h1);
        check("rst_first_ack", {28'b0, ack}, 32'h1);

        // single requester 2 streams 0x10..0x15: burst of 4, bubble, then 2 more
        tbl[0] = '{4'b0100, 32'h00100000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{4'b0100, 32'h00100000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h10};
        tbl[2] = '{4'b0100, 32'h00110000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h11};
        tbl[3] = '{4'b0100, 32'h00120000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h12};
        tbl[4] = '{4'b0100, 32'h00130000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h13};
        tbl[5] = '{4'b0100, 32'h00140000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[6] = '{4'b0100, 32'h00140000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h14};
        tbl[7] = '{4'b0100, 32'h00150000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h15};
        tbl[8] = '{4'b0000, 32'h00000000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00};
        tbl[9] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        do_reset();
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h10 + 8'(k));
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            req       = tbl[v].req;
            data      = tbl[v].data;
            fifo_full = tbl[v].full;
            #2;
            check("tbl_grant", {28'b0, grant}, {28'b0, tbl[v].e_grant});
            check("tbl_ack", {28'b0, ack}, {28'b0, tbl[v].e_ack});
            check("tbl_wr", {31'b0, fifo_wr}, {31'b0, tbl[v].e_wr});
            if (tbl[v].e_wr) begin
                check("tbl_wdata", {24'b0, fifo_w_data}, {24'b0, tbl[v].e_wdata});
                got_q.push_back(fifo_w_data);
            end
        end
        cmp_fifo("single");

        // all four requesting: 0,1,2,3 then back to 0, 16 words in 20 cycles
        do_reset();
        load(0, 8'h00, 8);
        load(1, 8'h10, 4);
        load(2, 8'h20, 4);
        load(3, 8'h30, 4);
        for (int c = 0; c < 20; c++) step(4'hF, 1'b0);
        check("rr_words_20cyc", got_q.size(), 16);
        for (int c = 0; c < 10; c++) step(4'hF, 1'b0);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h00 + 8'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h20 + 8'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h30 + 8'(k));
        for (int k = 4; k < 8; k++) exp_q.push_back(8'h00 + 8'(k));
        exp_g.push_back(8'h1);
        exp_g.push_back(8'h2);
        exp_g.push_back(8'h4);
        exp_g.push_back(8'h8);
        exp_g.push_back(8'h1);
        cmp_fifo("rr");
        cmp_grants("rr");

        // FIFO full for 3 cycles after requester 1's second word
        do_reset();
        load(1, 8'h20, 4);
        for (int c = 0; c < 10; c++) begin
            step(4'b0010, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                check("stall_wr", {31'b0, fifo_wr}, 32'h0);
                check("stall_ack", {28'b0, ack}, 32'h0);
                check("stall_grant", {28'b0, grant}, 32'h2);
            end
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h20 + 8'(k));
        exp_g.push_back(8'h2);
        cmp_fifo("stall");
        cmp_grants("stall");

        // requester 3 drops after one word; search wraps to requester 0
        do_reset();
        load(3, 8'h30, 1);
        load(0, 8'h40, 1);
        step(4'b1000, 1'b0);
        step(4'b1001, 1'b0);
        check("drop_c1_ack", {28'b0, ack}, 32'h8);
        step(4'b1001, 1'b0);
        check("drop_c2_grant", {28'b0, grant}, 32'h8);
        check("drop_c2_wr", {31'b0, fifo_wr}, 32'h0);
        step(4'b1001, 1'b0);
        check("drop_bubble", {28'b0, grant}, 32'h0);
        step(4'b1001, 1'b0);
        check("drop_wrap_grant", {28'b0, grant}, 32'h1);
        for (int c = 0; c < 3; c++) step(4'b1001, 1'b0);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        exp_g.push_back(8'h8);
        exp_g.push_back(8'h1);
        cmp_fifo("drop");
        cmp_grants("drop");

        // reset during requester 2's third word; it must be re-sent later
        do_reset();
        load(2, 8'h50, 6);
        load(1, 8'h60, 2);
        for (int c = 0; c < 3; c++) step(4'b0100, 1'b0);
        @(negedge clk);
        drive(4'b0100, 1'b0);
        #2;
        check("mid_pre_wr", {31'b0, fifo_wr}, 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_grant", {28'b0, grant}, 32'h0);
        check("mid_rst_wr", {31'b0, fifo_wr}, 32'h0);
        check("mid_rst_ack", {28'b0, ack}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        prev_grant = 4'b0000;
        drive(4'b0110, 1'b0);
        for (int c = 0; c < 14; c++) step(4'b0110, 1'b0);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h61);
        for (int k = 2; k < 6; k++) exp_q.push_back(8'h50 + 8'(k));
        exp_g.push_back(8'h4);
        exp_g.push_back(8'h2);
        exp_g.push_back(8'h4);
        cmp_fifo("mid_rst");
        cmp_grants("mid_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one FIFO write port among N producers using round-robin arbitration with a bounded burst length.
- Sits directly in front of the team FIFO, driving its wr/w_data and observing its full flag.
- Each requester streams words with a req/ack handshake; the arbiter holds a grant for up to BURST accepted words, then rotates.

Parameters:
B, 8, data word width in bits (matches FIFO B)
N, 4, number of requesters (2..16)
BURST, 4, max words accepted per grant (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately
req  input  N  req[i]=1: requester i presents a valid word on its data slice
data  input  N*B  flattened words; requester i occupies bits [i*B +: B]
ack  output  N  ack[i]=1: requester i's word written this cycle; one-hot or zero
grant  output  N  registered one-hot current owner; zero in IDLE
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe
fifo_w_data  output  B  FIFO write data

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, owner=0, cnt=0, last_owner=N-1 (requester 0 has first priority). Combinational outputs then give fifo_wr=0, ack=0, fifo_w_data=data slice 0.
- Requester rules:
  - Holds req and its data stable until ack.
  - On ack, presents its next word (req stays 1) or drops req.
  - Never drops req before ack.
- States: IDLE, GRANT.
- IDLE:
  - If any req, search indices last_owner+1 .. last_owner+N, wrapping mod N; first set bit becomes owner.
  - Registers grant=onehot(owner), cnt=0, next state GRANT.
  - Arbitration costs one cycle; fifo_wr=0 in IDLE.
- GRANT, combinational outputs:
  - fifo_wr = req[owner] & ~fifo_full.
  - fifo_w_data = data slice of owner.
  - ack[owner] = fifo_wr.
  - Zero-latency handshake: word is written on the same edge it is acked.
- GRANT, per edge:
  - fifo_wr=1 and cnt==BURST-1: release.
  - fifo_wr=1 otherwise: cnt<=cnt+1, stay in GRANT.
  - req[owner]=0: release, no write that cycle.
  - fifo_full=1 with req[owner]=1: stall. Grant and cnt hold, no ack, no timeout.
- Release: state<=IDLE, grant<=0, last_owner<=owner. There is always one bubble cycle between grants.
- Counter: cnt is $clog2(BURST)+1 bits wide and never exceeds BURST-1. With BURST=1, every accepted word releases.
- Wrap-around: the search wraps from N-1 to 0. A sole requester is re-granted after each bubble.
- Simultaneous events:
  - Requests from non-owners during GRANT are ignored until the next IDLE.
  - A req rising in the release cycle is seen in the following IDLE.
- fifo_wr is never asserted while fifo_full=1, so the FIFO never sees a dropped write.
- Reset mid-burst: outputs clear at once. The partial word is not acked, so the requester still holds it and it is not lost.
- Non-owner ack bits are always 0.

Test Plan:
- Reset: hold reset=0 with req=4'hF -> grant=0, ack=0, fifo_wr=0. First edge after release enters GRANT with grant=4'b0001.
- Single requester 2 sends 6 words 0x10..0x15, fifo_full=0 -> grant=4'b0100. 0x10-0x13 written on 4 consecutive edges, 1 IDLE bubble, re-grant, 0x14/0x15 written, then req drops and the block returns to IDLE. FIFO holds 0x10..0x15 in order.
- req=4'hF held continuously, every requester streaming unique tagged words -> grant sequence 0,1,2,3,0. Exactly 4 words per grant, 16 words in 20 cycles, FIFO contents grouped by requester in that order.
- Requester 1 owns the grant; fifo_full=1 for 3 cycles after its 2nd word -> fifo_wr=0, ack=0, grant held for those cycles. Then 2 more words are written: 4 total, no duplicates or drops.
- Requester 3 owns the grant and drops req after 1 word while req[0]=1 -> release, bubble, then grant=4'b0001 because the search wraps from last_owner=3.
- Assert reset=0 during requester 2's 3rd word -> grant/fifo_wr/ack go 0 asynchronously. After release with req=4'b0110, requester 1 is granted first; requester 2 then re-sends the unacked word.
